// File: rtl/qmath_pkg.sv
// Shared Q16.16 math definitions for the divider arbiter and its neighbours.
//   Q16_ONE / Q16_MAX / Q16_MIN : fixed-point constants (1.0, +max, -max)
//   state_t and ST_*            : arbiter FSM encoding
package qmath_pkg;

  localparam logic [31:0] Q16_ONE = 32'h0001_0000;
  localparam logic [31:0] Q16_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] Q16_MIN = 32'h8000_0001;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

endpackage

// File: rtl/qdiv_arbiter_rr_pick.sv
// Round-robin picker: returns the first asserted request at or after the
// pointer, wrapping around. Purely combinational.
//   req  in  N_REQ  request vector
//   ptr  in  IW     index where the search starts
//   pick out N_REQ  one-hot winner, zero if no request
//   idx  out IW     index of the winner
//   any  out 1      at least one request present
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    idx,
  output logic             any
);

  always_comb begin
    int k;
    k    = 0;
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (int'(ptr) + i) % N_REQ;
      if (!any && req[k]) begin
        any     = 1'b1;
        pick[k] = 1'b1;
        idx     = IW'(k);
      end
    end
  end

endmodule

// File: rtl/qdiv_arbiter.sv
// Shares one sequential Q16.16 divider among N_REQ requesters. Round-robin
// grant, one division in flight, results returned with a one-cycle ack.
// Zero divisors are answered locally with a saturated quotient.
//   clk, rst_n                 clock, asynchronous active-low reset
//   req                        per-requester request level, held until ack
//   dividend_i, divisor_i      packed operands, slice k = [k*W +: W]
//   grant                      one-hot owner of the divider, 0 when idle
//   ack, quotient_o, warn_o    one-cycle response to the owner
//   div_start, div_dividend,
//   div_divisor                start/operand interface towards the divider
//   div_valid, div_quotient,
//   div_warn                   completion interface from the divider
module qdiv_arbiter
  import qmath_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] dividend_i,
  input  logic [N_REQ*W-1:0] divisor_i,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   ack,
  output logic [W-1:0]       quotient_o,
  output logic               warn_o,
  output logic               div_start,
  output logic [W-1:0]       div_dividend,
  output logic [W-1:0]       div_divisor,
  input  logic               div_valid,
  input  logic [W-1:0]       div_quotient,
  input  logic               div_warn
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT) + 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

  // Saturated results for a zero divisor; with W=32 these are Q16_MAX / Q16_MIN.
  localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-2){1'b0}}, 1'b1};

  state_t           state;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    rr_ptr;
  logic [CW-1:0]    wait_cnt;
  logic             dropped;

  logic [N_REQ-1:0] pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  logic             finish;
  logic [W-1:0]     res_q;
  logic             res_w;
  logic             keep;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req  (req),
    .ptr  (rr_ptr),
    .pick (pick_onehot),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // A zero divisor never reaches the divider; the job is finished straight
  // out of ISSUE instead.
  assign div_start = (state == ST_ISSUE) && (div_divisor != '0);

  // The ack is only owed if the owner kept its request up for the whole job.
  assign keep = req[owner] && !dropped;

  // Decide whether the current job completes this cycle and with what result.
  always_comb begin
    finish = 1'b0;
    res_q  = '0;
    res_w  = 1'b0;
    case (state)
      ST_ISSUE: begin
        if (div_divisor == '0) begin
          finish = 1'b1;
          res_q  = div_dividend[W-1] ? SAT_NEG : SAT_POS;
          res_w  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (div_valid) begin
          finish = 1'b1;
          res_q  = div_quotient;
          res_w  = div_warn;
        end else if (wait_cnt == TO_LAST) begin
          finish = 1'b1;
          res_w  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Response outputs default to zero every cycle so they form a single-cycle
  // pulse. The round-robin pointer moves past the owner even when the ack is
  // suppressed, so an abandoned requester cannot hog the next slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      owner        <= '0;
      rr_ptr       <= '0;
      wait_cnt     <= '0;
      dropped      <= 1'b0;
      grant        <= '0;
      ack          <= '0;
      quotient_o   <= '0;
      warn_o       <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
    end else begin
      ack        <= '0;
      quotient_o <= '0;
      warn_o     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant        <= pick_onehot;
            owner        <= pick_idx;
            div_dividend <= dividend_i[int'(pick_idx)*W +: W];
            div_divisor  <= divisor_i[int'(pick_idx)*W +: W];
            dropped      <= 1'b0;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          if (!req[owner]) begin
            dropped <= 1'b1;
          end
          if (finish) begin
            state <= ST_RESP;
            grant <= '0;
            if (keep) begin
              ack        <= grant;
              quotient_o <= res_q;
              warn_o     <= res_w;
            end
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (!req[owner]) begin
            dropped <= 1'b1;
          end
          if (finish) begin
            state <= ST_RESP;
            grant <= '0;
            if (keep) begin
              ack        <= grant;
              quotient_o <= res_q;
              warn_o     <= res_w;
            end
          end
        end
        ST_RESP: begin
          rr_ptr <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
